ex_mem_skid_stage: RTL and testbench

Pipeline boundary between the execute stage (ALU, logical, shift units) and the memory stage. Captures one execute result per cycle with a valid/ready handshake and carries it to memory. A one-entry skid buffer absorbs a memory-side stall without a combinational ready path back into execute. Both held entries are exposed as forwarding sources for execute-stage operand bypass.

---
 rtl/ex_mem_skid_stage_if.sv | 49 ++++
 rtl/ex_mem_skid_stage.sv | 109 ++++++++++
 tb/tb_ex_mem_skid_stage.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_skid_stage_if.sv
// Signal bundle between execute, the EX/MEM pipeline stage and the memory stage.
// The stage itself uses the slave modport. The execute/memory side uses master.
interface ex_mem_skid_stage_if #(
    parameter int SIZE = 32
);
    logic            flush;
    logic            ex_valid;
    logic            ex_ready;
    logic [SIZE-1:0] ex_alu_result;
    logic [SIZE-1:0] ex_store_data;
    logic [4:0]      ex_rd;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_reg_write;
    logic [2:0]      ex_funct3;

    logic            mem_valid;
    logic            mem_ready;
    logic [SIZE-1:0] mem_alu_result;
    logic [SIZE-1:0] mem_store_data;
    logic [4:0]      mem_rd;
    logic            mem_mem_read;
    logic            mem_mem_write;
    logic            mem_reg_write;
    logic [2:0]      mem_funct3;

    logic            fwd_a_valid;
    logic [4:0]      fwd_a_rd;
    logic [SIZE-1:0] fwd_a_data;
    logic            fwd_b_valid;
    logic [4:0]      fwd_b_rd;
    logic [SIZE-1:0] fwd_b_data;

    modport master (
        output flush, ex_valid, ex_alu_result, ex_store_data, ex_rd,
               ex_mem_read, ex_mem_write, ex_reg_write, ex_funct3, mem_ready,
        input  ex_ready, mem_valid, mem_alu_result, mem_store_data, mem_rd,
               mem_mem_read, mem_mem_write, mem_reg_write, mem_funct3,
               fwd_a_valid, fwd_a_rd, fwd_a_data, fwd_b_valid, fwd_b_rd, fwd_b_data
    );

    modport slave (
        input  flush, ex_valid, ex_alu_result, ex_store_data, ex_rd,
               ex_mem_read, ex_mem_write, ex_reg_write, ex_funct3, mem_ready,
        output ex_ready, mem_valid, mem_alu_result, mem_store_data, mem_rd,
               mem_mem_read, mem_mem_write, mem_reg_write, mem_funct3,
               fwd_a_valid, fwd_a_rd, fwd_a_data, fwd_b_valid, fwd_b_rd, fwd_b_data
    );
endinterface

// File: rtl/ex_mem_skid_stage.sv
// EX/MEM pipeline register with a one-entry skid buffer; ex_ready depends on state only.
// Both held entries are exposed as operand-bypass sources for execute.
module ex_mem_skid_stage #(
    parameter int SIZE = 32
) (
    input  logic               clk,
    input  logic               reset,
    ex_mem_skid_stage_if.slave bus
);
    typedef struct packed {
        logic [SIZE-1:0] alu_result;
        logic [SIZE-1:0] store_data;
        logic [4:0]      rd;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic [2:0]      funct3;
    } entry_t;

    // Encoding keeps bit 0 = main valid and bit 1 = skid valid.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b11
    } state_t;

    state_t r_state;
    entry_t r_main;
    entry_t r_skid;
    entry_t w_in;
    logic   w_main_valid;
    logic   w_skid_valid;
    logic   w_ex_ready;
    logic   w_accept;
    logic   w_drain;

    assign w_in = '{
        alu_result: bus.ex_alu_result,
        store_data: bus.ex_store_data,
        rd:         bus.ex_rd,
        mem_read:   bus.ex_mem_read,
        mem_write:  bus.ex_mem_write,
        reg_write:  bus.ex_reg_write,
        funct3:     bus.ex_funct3
    };

    assign w_main_valid = (r_state != EMPTY);
    assign w_skid_valid = (r_state == SKID);
    assign w_ex_ready   = reset && !w_skid_valid;
    assign w_accept     = bus.ex_valid && w_ex_ready && !bus.flush;
    assign w_drain      = w_main_valid && bus.mem_ready;

    // Flush drops the valid bits only; payload registers keep stale contents.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (bus.flush) begin
            r_state <= EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_main  <= w_in;
                        r_state <= FULL;
                    end
                end
                FULL: begin
                    if (w_accept && w_drain) begin
                        r_main <= w_in;
                    end else if (w_drain) begin
                        r_state <= EMPTY;
                    end else if (w_accept) begin
                        r_skid  <= w_in;
                        r_state <= SKID;
                    end
                end
                SKID: begin
                    if (w_drain) begin
                        r_main  <= r_skid;
                        r_state <= FULL;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign bus.ex_ready       = w_ex_ready;
    assign bus.mem_valid      = w_main_valid;
    assign bus.mem_alu_result = r_main.alu_result;
    assign bus.mem_store_data = r_main.store_data;
    assign bus.mem_rd         = r_main.rd;
    assign bus.mem_mem_read   = r_main.mem_read;
    assign bus.mem_mem_write  = r_main.mem_write;
    assign bus.mem_reg_write  = r_main.reg_write;
    assign bus.mem_funct3     = r_main.funct3;

    // Loads carry an address in alu_result, so they are never bypass sources.
    assign bus.fwd_a_valid = w_main_valid && r_main.reg_write && !r_main.mem_read
                             && (r_main.rd != 5'd0);
    assign bus.fwd_a_rd    = r_main.rd;
    assign bus.fwd_a_data  = r_main.alu_result;
    assign bus.fwd_b_valid = w_skid_valid && r_skid.reg_write && !r_skid.mem_read
                             && (r_skid.rd != 5'd0);
    assign bus.fwd_b_rd    = r_skid.rd;
    assign bus.fwd_b_data  = r_skid.alu_result;
endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Scoreboard bench for ex_mem_skid_stage: the driver pushes accepted instructions,
// the negedge monitor compares the memory-side and bypass outputs against them.
module tb_ex_mem_skid_stage;
    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] store;
        logic [4:0]  rd;
        logic        isLoad;
        logic        isStore;
        logic        regWrite;
        logic [2:0]  funct3;
    } entry_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    ex_mem_skid_stage_if #(.SIZE(32)) bus ();

    ex_mem_skid_stage #(.SIZE(32)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int     errors = 0;
    int     checks = 0;
    entry_t expQ[$];
    int     occNow = 0;
    int     occNext = 0;
    bit     pendingClear = 1'b0;
    bit     zeroCheck = 1'b0;
    bit     started = 1'b0;

    // A result may be bypassed only if it writes a nonzero register and is not a load.
    function automatic logic fwdOk(input entry_t e);
        return e.regWrite && !e.isLoad && (e.rd != 5'd0);
    endfunction

    function automatic entry_t mk(input logic [31:0] alu, input logic [4:0] rd,
                                  input logic regWrite, input logic isLoad);
        entry_t e;
        e.alu      = alu;
        e.store    = alu ^ 32'hA5A5_0000;
        e.rd       = rd;
        e.isLoad   = isLoad;
        e.isStore  = 1'b0;
        e.regWrite = regWrite;
        e.funct3   = 3'd2;
        return e;
    endfunction

    function automatic entry_t randEntry();
        entry_t e;
        e.alu      = $urandom;
        e.store    = $urandom;
        e.rd       = 5'($urandom_range(0, 3));
        e.isLoad   = ($urandom_range(0, 3) == 0);
        e.isStore  = 1'($urandom_range(0, 1));
        e.regWrite = 1'($urandom_range(0, 1));
        e.funct3   = 3'($urandom_range(0, 7));
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock of stimulus; the reference occupancy advances by the handshake rules.
    task automatic applyStimulus(input bit v, input entry_t e, input bit mr,
                                 input bit fl, input bit rstN);
        bit drain;
        bit acc;
        @(posedge clk);
        #1;
        occNow = occNext;
        if (pendingClear) begin
            expQ.delete();
            pendingClear = 1'b0;
        end
        started = 1'b1;
        checkOutput("ex_ready", 64'(bus.ex_ready), 64'(reset && (occNow < 2)));
        checkOutput("mem_valid", 64'(bus.mem_valid), 64'(occNow > 0));
        if (zeroCheck) begin
            checkOutput("reset_alu", 64'(bus.mem_alu_result), 64'd0);
            checkOutput("reset_store", 64'(bus.mem_store_data), 64'd0);
            checkOutput("reset_ctrl", 64'({bus.mem_rd, bus.mem_mem_read, bus.mem_mem_write,
                                           bus.mem_reg_write, bus.mem_funct3}), 64'd0);
            checkOutput("reset_fwd", 64'({bus.fwd_a_valid, bus.fwd_b_valid}), 64'd0);
            zeroCheck = 1'b0;
        end

        reset             = rstN;
        bus.flush         = fl;
        bus.ex_valid      = v;
        bus.ex_alu_result = e.alu;
        bus.ex_store_data = e.store;
        bus.ex_rd         = e.rd;
        bus.ex_mem_read   = e.isLoad;
        bus.ex_mem_write  = e.isStore;
        bus.ex_reg_write  = e.regWrite;
        bus.ex_funct3     = e.funct3;
        bus.mem_ready     = mr;

        if (!rstN) begin
            occNext      = 0;
            pendingClear = 1'b1;
            zeroCheck    = 1'b1;
        end else if (fl) begin
            occNext      = 0;
            pendingClear = 1'b1;
        end else begin
            drain   = (occNow > 0) && mr;
            acc     = v && (occNow < 2);
            occNext = occNow - int'(drain) + int'(acc);
            if (acc) expQ.push_back(e);
        end
    endtask

    // Monitor: the first occNow queue entries are what the stage currently holds.
    always @(negedge clk) begin
        if (started) begin
            if (occNow > 0 && expQ.size() > 0) begin
                checkOutput("mem_alu_result", 64'(bus.mem_alu_result), 64'(expQ[0].alu));
                checkOutput("mem_store_data", 64'(bus.mem_store_data), 64'(expQ[0].store));
                checkOutput("mem_ctrl",
                    64'({bus.mem_rd, bus.mem_mem_read, bus.mem_mem_write, bus.mem_reg_write, bus.mem_funct3}),
                    64'({expQ[0].rd, expQ[0].isLoad, expQ[0].isStore, expQ[0].regWrite, expQ[0].funct3}));
                checkOutput("fwd_a_valid", 64'(bus.fwd_a_valid), 64'(fwdOk(expQ[0])));
                checkOutput("fwd_a_rd_data", 64'({bus.fwd_a_rd, bus.fwd_a_data}),
                            64'({expQ[0].rd, expQ[0].alu}));
                if (occNow == 2 && expQ.size() > 1) begin
                    checkOutput("fwd_b_valid", 64'(bus.fwd_b_valid), 64'(fwdOk(expQ[1])));
                    checkOutput("fwd_b_rd_data", 64'({bus.fwd_b_rd, bus.fwd_b_data}),
                                64'({expQ[1].rd, expQ[1].alu}));
                end else begin
                    checkOutput("fwd_b_idle", 64'(bus.fwd_b_valid), 64'd0);
                end
                if (bus.mem_ready) void'(expQ.pop_front());
            end else begin
                checkOutput("fwd_idle", 64'({bus.fwd_a_valid, bus.fwd_b_valid}), 64'd0);
            end
        end
    end

    entry_t idle;

    initial begin
        idle              = mk(32'h0, 5'd0, 1'b0, 1'b0);
        bus.flush         = 1'b0;
        bus.ex_valid      = 1'b0;
        bus.ex_alu_result = '0;
        bus.ex_store_data = '0;
        bus.ex_rd         = '0;
        bus.ex_mem_read   = 1'b0;
        bus.ex_mem_write  = 1'b0;
        bus.ex_reg_write  = 1'b0;
        bus.ex_funct3     = '0;
        bus.mem_ready     = 1'b0;

        applyStimulus(0, idle, 0, 0, 0);
        applyStimulus(0, idle, 0, 0, 1);

        // Streaming with memory always ready
        for (int i = 1; i <= 8; i++) applyStimulus(1, mk(32'(i), 5'(i), 1, 0), 1, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, idle, 1, 0, 1);

        // Stall into the skid entry, then release
        applyStimulus(1, mk(32'h11, 5'd1, 1, 0), 0, 0, 1);
        applyStimulus(1, mk(32'h22, 5'd2, 1, 0), 0, 0, 1);
        applyStimulus(1, mk(32'h33, 5'd3, 1, 0), 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, idle, 1, 0, 1);

        // Flush while in SKID with a new instruction offered
        applyStimulus(1, mk(32'h44, 5'd4, 1, 0), 0, 0, 1);
        applyStimulus(1, mk(32'h55, 5'd5, 1, 0), 0, 0, 1);
        applyStimulus(1, mk(32'hDEAD, 5'd6, 1, 0), 0, 1, 1);
        for (int i = 0; i < 2; i++) applyStimulus(0, idle, 1, 0, 1);

        // Forwarding from both entries, then loads and rd=0
        applyStimulus(1, mk(32'h1234, 5'd5, 1, 0), 0, 0, 1);
        applyStimulus(1, mk(32'hBEEF, 5'd5, 1, 0), 0, 0, 1);
        applyStimulus(0, idle, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, idle, 1, 0, 1);
        applyStimulus(1, mk(32'h77, 5'd5, 1, 1), 0, 0, 1);
        applyStimulus(1, mk(32'h88, 5'd0, 1, 0), 0, 0, 1);
        applyStimulus(0, idle, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, idle, 1, 0, 1);

        // Reset asserted mid-SKID
        applyStimulus(1, mk(32'h99, 5'd7, 1, 0), 0, 0, 1);
        applyStimulus(1, mk(32'hAA, 5'd8, 1, 0), 0, 0, 1);
        applyStimulus(1, mk(32'hBB, 5'd9, 1, 0), 0, 0, 0);
        applyStimulus(0, idle, 0, 0, 0);
        applyStimulus(0, idle, 1, 0, 1);
        applyStimulus(0, idle, 1, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 9) < 7), randEntry(),
                          ($urandom_range(0, 9) < 6), ($urandom_range(0, 29) == 0),
                          ($urandom_range(0, 59) != 0));
        end
        for (int i = 0; i < 4; i++) applyStimulus(0, idle, 1, 0, 1);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
